aes_resp_misr: RTL and testbench

- Response-side sink for the AES-128 pipeline: the stimulus LFSRs generate plaintext/key, and this block consumes the ciphertext stream and compacts it into a 128-bit MISR signature.
- Skips the pipeline-fill latency, absorbs exactly N results, then compares the signature against an expected value.
- Sits beside aes_128 on the same clock; lets regressions pass/fail without storing every ciphertext.

---
 rtl/aes_resp_misr.sv | 109 ++++++++++
 tb/tb_aes_resp_misr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_resp_misr.sv
// rtl/aes_resp_misr.sv - AES-128 response MISR: skips pipeline fill, absorbs N ciphertexts, compares signature.
// Optional AES_RESP_CAPTURE_EN adds o_first_data/o_last_data capture registers.
module aes_resp_misr #(
    parameter int           NUM_BITS = 128,
    parameter int           LATENCY  = 21,
    parameter int           CNT_W    = 32,
    parameter logic [127:0] SEED     = 128'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [CNT_W-1:0]    i_num_tests,
    input  logic                i_enable,
    input  logic [NUM_BITS-1:0] i_data,
    input  logic [NUM_BITS-1:0] i_expected_sig,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_match,
    output logic [NUM_BITS-1:0] o_signature,
`ifdef AES_RESP_CAPTURE_EN
    output logic [NUM_BITS-1:0] o_first_data,
    output logic [NUM_BITS-1:0] o_last_data,
`endif
    output logic [CNT_W-1:0]    o_count
);

    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam int LAT_LAST = (LATENCY >= 2) ? LATENCY - 1 : 1;

    typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               fb;

    assign lat_nxt = lat_cnt + LAT_W'(1);
    assign cnt_nxt = o_count + CNT_W'(1);
    assign fb      = o_signature[127] ^ o_signature[125] ^ o_signature[100] ^ o_signature[98];
    assign o_match = o_done && (o_signature == i_expected_sig);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            num_q       <= '0;
            lat_cnt     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_signature <= '0;
            o_count     <= '0;
`ifdef AES_RESP_CAPTURE_EN
            o_first_data <= '0;
            o_last_data  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        num_q       <= i_num_tests;
                        o_signature <= SEED;
                        o_count     <= '0;
                        lat_cnt     <= '0;
`ifdef AES_RESP_CAPTURE_EN
                        o_first_data <= '0;
                        o_last_data  <= '0;
`endif
                        if (i_num_tests == '0) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            // A one-cycle pipeline has no fill phase at all.
                            state  <= (LATENCY <= 1) ? CAPTURE : FILL;
                            o_busy <= 1'b1;
                            o_done <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    // Leaving when the count reaches LATENCY-1 makes the next
                    // enabled cycle the LATENCY-th one after start.
                    if (i_enable) begin
                        lat_cnt <= lat_nxt;
                        if (lat_nxt == LAT_W'(LAT_LAST)) state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (i_enable) begin
                        o_signature <= {o_signature[126:0], fb} ^ i_data;
                        o_count     <= cnt_nxt;
`ifdef AES_RESP_CAPTURE_EN
                        if (o_count == '0) o_first_data <= i_data;
                        o_last_data <= i_data;
`endif
                        if (cnt_nxt == num_q) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_resp_misr.sv
// tb/tb_aes_resp_misr.sv - scoreboard bench for aes_resp_misr.
module tb_aes_resp_misr;

    localparam logic [127:0] SEED_V = 128'h0;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [31:0]  i_num_tests;
    logic         i_enable;
    logic [127:0] i_data;
    logic [127:0] i_expected_sig;
    logic         o_busy;
    logic         o_done;
    logic         o_match;
    logic [127:0] o_signature;
    logic [31:0]  o_count;
`ifdef AES_RESP_CAPTURE_EN
    logic [127:0] o_first_data;
    logic [127:0] o_last_data;
`endif

    aes_resp_misr dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_num_tests    (i_num_tests),
        .i_enable       (i_enable),
        .i_data         (i_data),
        .i_expected_sig (i_expected_sig),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_match        (o_match),
        .o_signature    (o_signature),
`ifdef AES_RESP_CAPTURE_EN
        .o_first_data   (o_first_data),
        .o_last_data    (o_last_data),
`endif
        .o_count        (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] sig;
        logic [31:0]  cnt;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    logic [127:0] model_sig;
    logic [31:0]  model_cnt;
    logic [31:0]  prev_cnt = '0;
    logic [127:0] first_d, last_d;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] misr_next(input logic [127:0] m, input logic [127:0] d);
        logic f;
        f = m[127] ^ m[125] ^ m[100] ^ m[98];
        return {m[126:0], f} ^ d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Each change of o_count must match the next absorbed result the bench predicted.
    always @(negedge clk) begin
        if (o_count !== prev_cnt) begin
            if (o_count != 0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 128'(o_count), 128'(prev_cnt));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_sig", o_signature, e.sig);
                    check("sb_cnt", 128'(o_count), 128'(e.cnt));
                end
            end
            prev_cnt = o_count;
        end
    end

    task automatic drive(input logic st, input logic [31:0] n, input logic en,
                         input logic [127:0] d, input logic absorb, input logic r);
        rst         = r;
        i_start     = st;
        i_num_tests = n;
        i_enable    = en;
        i_data      = d;
        if (absorb) begin
            model_sig = misr_next(model_sig, d);
            model_cnt = model_cnt + 1;
            if (model_cnt == 1) first_d = d;
            last_d = d;
            exp_q.push_back('{model_sig, model_cnt});
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] n);
        drive(1'b1, n, 1'b1, rnd128(), 1'b0, 1'b0);
        model_sig = SEED_V;
        model_cnt = 0;
        first_d   = '0;
        last_d    = '0;
        if (n != 0) begin
            for (int i = 1; i <= 20; i++)
                drive(1'b0, 32'd0, 1'b1, (i == 20) ? 128'hF : rnd128(), 1'b0, 1'b0);
        end
    endtask

    task automatic absorb(input logic [127:0] d);
        drive(1'b0, 32'd0, 1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic gap(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 32'd0, 1'b0, rnd128(), 1'b0, 1'b0);
    endtask

    initial begin
        logic [127:0] a, b, c;
        i_expected_sig = '0;
        model_sig = '0;
        model_cnt = 0;
        drive(1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1);
        check("rst_busy",  128'(o_busy), 128'd0);
        check("rst_done",  128'(o_done), 128'd0);
        check("rst_match", 128'(o_match), 128'd0);
        check("rst_sig",   o_signature, 128'd0);
        check("rst_cnt",   128'(o_count), 128'd0);

        // N=1: cycle-20 value must be skipped, cycle-21 value absorbed.
        start_run(32'd1);
        check("n1_busy_fill", 128'(o_busy), 128'd1);
        absorb(128'h1);
        check("n1_done", 128'(o_done), 128'd1);
        check("n1_busy", 128'(o_busy), 128'd0);
        check("n1_sig",  o_signature, 128'h1);
        check("n1_cnt",  128'(o_count), 128'd1);

        // N=2 back to back, match then mismatch on the held signature.
        i_expected_sig = 128'h3;
        start_run(32'd2);
        absorb(128'h1);
        absorb(128'h1);
        check("n2_sig",   o_signature, 128'h3);
        check("n2_match", 128'(o_match), 128'd1);
        i_expected_sig = 128'h2;
        #1;
        check("n2_nomatch", 128'(o_match), 128'd0);

        // N=2 with a five-cycle enable gap.
        start_run(32'd2);
        absorb(128'h1);
        gap(5);
        check("gap_cnt",  128'(o_count), 128'd1);
        check("gap_busy", 128'(o_busy), 128'd1);
        absorb(128'h1);
        check("gap_sig", o_signature, 128'h3);
        check("gap_done", 128'(o_done), 128'd1);

        // N=0 goes straight to DONE holding the seed.
        start_run(32'd0);
        check("n0_done", 128'(o_done), 128'd1);
        check("n0_busy", 128'(o_busy), 128'd0);
        check("n0_sig",  o_signature, SEED_V);
        check("n0_cnt",  128'(o_count), 128'd0);

        // Reset on enabled cycle 22 of an N=4 run, then a fresh run.
        start_run(32'd4);
        absorb(rnd128());
        drive(1'b0, 32'd0, 1'b1, rnd128(), 1'b0, 1'b1);
        check("rrst_busy", 128'(o_busy), 128'd0);
        check("rrst_done", 128'(o_done), 128'd0);
        check("rrst_sig",  o_signature, 128'd0);
        check("rrst_cnt",  128'(o_count), 128'd0);
        gap(2);
        a = rnd128();
        start_run(32'd1);
        absorb(a);
        check("fresh_sig",  o_signature, a);
        check("fresh_done", 128'(o_done), 128'd1);

        // Start pulse mid-CAPTURE is ignored and its cycle is still absorbed.
        a = rnd128(); b = rnd128(); c = rnd128();
        start_run(32'd3);
        absorb(a);
        drive(1'b1, 32'd0, 1'b1, b, 1'b1, 1'b0);
        check("mid_busy", 128'(o_busy), 128'd1);
        absorb(c);
        check("mid_cnt",  128'(o_count), 128'd3);
        check("mid_sig",  o_signature, model_sig);
        check("mid_done", 128'(o_done), 128'd1);
`ifdef AES_RESP_CAPTURE_EN
        check("cap_first", o_first_data, first_d);
        check("cap_last",  o_last_data, last_d);
`endif

        // Random data with random enable gaps.
        start_run(32'd5);
        for (int i = 0; i < 5; i++) begin
            absorb(rnd128());
            gap($urandom_range(0, 3));
        end
        i_expected_sig = model_sig;
        #1;
        check("rnd_match", 128'(o_match), 128'd1);
        check("rnd_cnt",   128'(o_count), 128'd5);

        gap(2);
        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
